// File: rtl/ip_tx_arbiter_if.sv
// Handshake/bus bundle between result sources, ip_tx_arbiter and ip_packet_tx.
// master = arbiter view, slave = requesters plus transmitter view.
interface ip_tx_arbiter_if #(
  parameter int NUM_REQ          = 2,
  parameter int IP_ADDR_WIDTH    = 32,
  parameter int MAC_ADDR_WIDTH   = 48,
  parameter int UDP_PORT_WIDTH   = 16,
  parameter int ACCEL_DATA_WIDTH = 10
);
  logic [NUM_REQ-1:0]                      REQ_VALID;
  logic [NUM_REQ-1:0]                      REQ_READY;
  logic [0:NUM_REQ*IP_ADDR_WIDTH-1]        REQ_IP_ADDRESS;
  logic [0:NUM_REQ*MAC_ADDR_WIDTH-1]       REQ_MAC_ADDRESS;
  logic [0:NUM_REQ*UDP_PORT_WIDTH-1]       REQ_UDP_PORT;
  logic [0:NUM_REQ*ACCEL_DATA_WIDTH-1]     REQ_MESSAGE;
  logic [IP_ADDR_WIDTH-1:0]                RECIPIENT_IP_ADDRESS;
  logic [MAC_ADDR_WIDTH-1:0]               RECIPIENT_MAC_ADDRESS;
  logic [UDP_PORT_WIDTH-1:0]               RECIPIENT_UDP_PORT;
  logic [ACCEL_DATA_WIDTH-1:0]             RECIPIENT_MESSAGE;
  logic                                    START_IP_TXN;
  logic                                    READY_FOR_SEND;
  logic                                    MAC_DATA_VALID;
  logic                                    MAC_DATA_READY;
  logic                                    MAC_DATA_LAST;
  logic                                    BUSY;
  logic [2:0]                              GRANT_ID;
  logic [15:0]                             PACKET_COUNT;

  modport master (
    input  REQ_VALID, REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_UDP_PORT, REQ_MESSAGE,
           READY_FOR_SEND, MAC_DATA_VALID, MAC_DATA_READY, MAC_DATA_LAST,
    output REQ_READY, RECIPIENT_IP_ADDRESS, RECIPIENT_MAC_ADDRESS, RECIPIENT_UDP_PORT,
           RECIPIENT_MESSAGE, START_IP_TXN, BUSY, GRANT_ID, PACKET_COUNT
  );

  modport slave (
    output REQ_VALID, REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_UDP_PORT, REQ_MESSAGE,
           READY_FOR_SEND, MAC_DATA_VALID, MAC_DATA_READY, MAC_DATA_LAST,
    input  REQ_READY, RECIPIENT_IP_ADDRESS, RECIPIENT_MAC_ADDRESS, RECIPIENT_UDP_PORT,
           RECIPIENT_MESSAGE, START_IP_TXN, BUSY, GRANT_ID, PACKET_COUNT
  );
endinterface

// File: rtl/ip_tx_arbiter.sv
// Round-robin (or fixed priority with IP_TX_ARB_STRICT_PRIO_EN) share of one ip_packet_tx; grant->launch 1 cycle,
// holds in LAUNCH while READY_FOR_SEND=0 and in SENDING until the last MAC beat handshakes.
module ip_tx_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int IP_ADDR_WIDTH    = 32,
  parameter int MAC_ADDR_WIDTH   = 48,
  parameter int UDP_PORT_WIDTH   = 16,
  parameter int ACCEL_DATA_WIDTH = 10
) (
  input  logic            ACLK,
  input  logic            ARESET,
  ip_tx_arbiter_if.master arb_bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, SENDING} state_t;

  state_t                      state, state_nxt;
  logic [PW-1:0]               ptr, ptr_nxt, win_idx, cand;
  logic                        win_vld, grant, start, last_beat;
  logic [NUM_REQ-1:0]          ready_vec;
  logic [IP_ADDR_WIDTH-1:0]    ip_q;
  logic [MAC_ADDR_WIDTH-1:0]   mac_q;
  logic [UDP_PORT_WIDTH-1:0]   port_q;
  logic [ACCEL_DATA_WIDTH-1:0] msg_q;
  logic [2:0]                  grant_id_q;
  logic [15:0]                 cnt_q;

  assign last_beat = arb_bus.MAC_DATA_VALID & arb_bus.MAC_DATA_READY & arb_bus.MAC_DATA_LAST;

  // First pending requester at or above the pointer, wrapping at NUM_REQ-1.
  always_comb begin : pick
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((k + int'(ptr)) % NUM_REQ);
      if (!win_vld && arb_bus.REQ_VALID[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef IP_TX_ARB_STRICT_PRIO_EN
  assign ptr_nxt = '0;
`else
  assign ptr_nxt = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif

  always_comb begin : fsm
    state_nxt = state;
    grant     = 1'b0;
    start     = 1'b0;
    ready_vec = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant     = 1'b1;
          ready_vec = NUM_REQ'(1) << win_idx;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (arb_bus.READY_FOR_SEND) begin
          start     = 1'b1;
          state_nxt = SENDING;
        end
      end
      SENDING: begin
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state      <= IDLE;
      ptr        <= '0;
      ip_q       <= '0;
      mac_q      <= '0;
      port_q     <= '0;
      msg_q      <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ip_q       <= arb_bus.REQ_IP_ADDRESS[int'(win_idx)*IP_ADDR_WIDTH +: IP_ADDR_WIDTH];
        mac_q      <= arb_bus.REQ_MAC_ADDRESS[int'(win_idx)*MAC_ADDR_WIDTH +: MAC_ADDR_WIDTH];
        port_q     <= arb_bus.REQ_UDP_PORT[int'(win_idx)*UDP_PORT_WIDTH +: UDP_PORT_WIDTH];
        msg_q      <= arb_bus.REQ_MESSAGE[int'(win_idx)*ACCEL_DATA_WIDTH +: ACCEL_DATA_WIDTH];
        grant_id_q <= 3'(win_idx);
        ptr        <= ptr_nxt;
      end
      if (state == SENDING && last_beat) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Gated by reset so no grant is offered while the block is held in reset.
  assign arb_bus.REQ_READY             = ARESET ? ready_vec : '0;
  assign arb_bus.START_IP_TXN          = start;
  assign arb_bus.BUSY                  = (state != IDLE);
  assign arb_bus.GRANT_ID              = grant_id_q;
  assign arb_bus.PACKET_COUNT          = cnt_q;
  assign arb_bus.RECIPIENT_IP_ADDRESS  = ip_q;
  assign arb_bus.RECIPIENT_MAC_ADDRESS = mac_q;
  assign arb_bus.RECIPIENT_UDP_PORT    = port_q;
  assign arb_bus.RECIPIENT_MESSAGE     = msg_q;
endmodule
